// File: rtl/sisc_mem_pkg.sv
// Shared constants for the SISC memory arbiter: FSM encoding, owner ids and default widths.
package sisc_mem_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/sisc_arb_pick.sv
// Winner selection between fetch and data plus the starvation counter that guarantees fetch progress.
// starve_hit exists only when SISC_MEM_ARB_STATS_EN is defined.
module sisc_arb_pick
    import sisc_mem_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst_f,
    input  logic i_req,
    input  logic d_req,
    input  logic grant,
    output logic winner
`ifdef SISC_MEM_ARB_STATS_EN
    ,
    output logic starve_hit
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       forced;

    // Fetch wins a conflict only once data has been granted STARVE_MAX times in a row over it.
    assign forced = i_req && d_req && (starve_cnt == STARVE_LIM);
    assign winner = (d_req && !forced) ? OWN_D : OWN_I;

`ifdef SISC_MEM_ARB_STATS_EN
    assign starve_hit = grant && forced;
`endif

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (winner == OWN_I) begin
                starve_cnt <= '0;
            end else if (i_req && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/sisc_mem_arb.sv
// Single-port SISC main-memory arbiter: fetch vs data, latch -> issue -> wait -> acknowledge.
// Optional statistics (conf_cnt, starve_hit) are built when SISC_MEM_ARB_STATS_EN is defined.
module sisc_mem_arb
    import sisc_mem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef SISC_MEM_ARB_STATS_EN
    ,
    output logic [15:0]   conf_cnt,
    output logic          starve_hit
`endif
);

    logic [1:0]    state;
    logic          owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [2:0]    wcnt;
    logic [DW-1:0] i_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          grant;
    logic          winner;

    assign grant = (state == ST_IDLE) && (i_req || d_req);

    sisc_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk       (clk),
        .rst_f     (rst_f),
        .i_req     (i_req),
        .d_req     (d_req),
        .grant     (grant),
        .winner    (winner)
`ifdef SISC_MEM_ARB_STATS_EN
        ,
        .starve_hit(starve_hit)
`endif
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state     <= ST_IDLE;
            owner_q   <= OWN_I;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wcnt      <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Latch the whole request so the requester may change inputs after the grant.
                    if (grant) begin
                        owner_q <= winner;
                        we_q    <= (winner == OWN_D) && d_we;
                        addr_q  <= (winner == OWN_D) ? d_addr : i_addr;
                        wdata_q <= (winner == OWN_D) ? d_wdata : '0;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wcnt  <= 3'(MEM_LAT);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wcnt == 3'd1) begin
                        if (!we_q) begin
                            if (owner_q == OWN_D) begin
                                d_rdata_q <= mem_rdata;
                            end else begin
                                i_rdata_q <= mem_rdata;
                            end
                        end
                        state <= ST_RESP;
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SISC_MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            conf_cnt <= '0;
        end else if ((state == ST_IDLE) && i_req && d_req && (conf_cnt != 16'hFFFF)) begin
            conf_cnt <= conf_cnt + 16'd1;
        end
    end
`endif

    // Memory bus is forced to zero outside the strobe cycle.
    assign mem_en    = (state == ST_ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

    assign i_ack   = (state == ST_RESP) && (owner_q == OWN_I);
    assign d_ack   = (state == ST_RESP) && (owner_q == OWN_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Bench for sisc_mem_arb: two instances (MEM_LAT=1 and MEM_LAT=4) share stimulus, each with its own memory model.
module tb_sisc_mem_arb;
    import sisc_mem_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int W  = 49;  // {owner, rdata, ack cycle}

    logic clk   = 1'b0;
    logic rst_f = 1'b1;
    always #5 clk = ~clk;

    logic          i_req   = 1'b0;
    logic          d_req   = 1'b0;
    logic          d_we    = 1'b0;
    logic [AW-1:0] i_addr  = '0;
    logic [AW-1:0] d_addr  = '0;
    logic [DW-1:0] d_wdata = '0;

    logic [DW-1:0] i_rdata_w   [2];
    logic [DW-1:0] d_rdata_w   [2];
    logic [DW-1:0] mem_wdata_w [2];
    logic [DW-1:0] mem_rdata_w [2];
    logic [AW-1:0] mem_addr_w  [2];
    logic          i_ack_w     [2];
    logic          d_ack_w     [2];
    logic          mem_en_w    [2];
    logic          mem_we_w    [2];
    logic          busy_w      [2];
`ifdef SISC_MEM_ARB_STATS_EN
    logic [15:0]   conf_cnt_w  [2];
    logic          starve_hit_w[2];
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    logic [W-1:0] exp_q[$];

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 1 : 4;
        logic [DW-1:0] mem  [0:1023];
        logic [DW-1:0] pipe [0:LAT-1];

        sisc_mem_arb #(
            .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(3)
        ) u_dut (
            .clk      (clk),
            .rst_f    (rst_f),
            .i_req    (i_req),
            .i_addr   (i_addr),
            .i_rdata  (i_rdata_w[g]),
            .i_ack    (i_ack_w[g]),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_rdata  (d_rdata_w[g]),
            .d_ack    (d_ack_w[g]),
            .mem_en   (mem_en_w[g]),
            .mem_we   (mem_we_w[g]),
            .mem_addr (mem_addr_w[g]),
            .mem_wdata(mem_wdata_w[g]),
            .mem_rdata(mem_rdata_w[g]),
            .busy     (busy_w[g])
`ifdef SISC_MEM_ARB_STATS_EN
            ,
            .conf_cnt  (conf_cnt_w[g]),
            .starve_hit(starve_hit_w[g])
`endif
        );

        // Read data appears exactly LAT cycles after the strobe; any other cycle carries a marker value.
        always @(posedge clk) begin
            if (!rst_f) begin
                for (int k = 0; k < 1024; k++) mem[k] <= '0;
                mem[10'h010] <= 32'h8000_0005;
                mem[10'h044] <= 32'hCAFE_0044;
                mem[10'h200] <= 32'h1234_5678;
            end else if (mem_en_w[g] && mem_we_w[g]) begin
                mem[mem_addr_w[g][9:0]] <= mem_wdata_w[g];
            end
            pipe[0] <= mem_en_w[g] ? mem[mem_addr_w[g][9:0]] : 32'hBAD0_0000;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata_w[g] = pipe[LAT-1];
    end

    int i_ack_cnt[2]    = '{0, 0};
    int d_ack_cnt[2]    = '{0, 0};
    int en_cnt[2]       = '{0, 0};
    int idle_bus_err[2] = '{0, 0};
    int hit_cnt[2]      = '{0, 0};

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (i_ack_w[g]) i_ack_cnt[g] <= i_ack_cnt[g] + 1;
            if (d_ack_w[g]) d_ack_cnt[g] <= d_ack_cnt[g] + 1;
            if (mem_en_w[g]) en_cnt[g] <= en_cnt[g] + 1;
            if (!mem_en_w[g] && (mem_we_w[g] || (mem_addr_w[g] != '0) || (mem_wdata_w[g] != '0)))
                idle_bus_err[g] <= idle_bus_err[g] + 1;
`ifdef SISC_MEM_ARB_STATS_EN
            if (starve_hit_w[g]) hit_cnt[g] <= hit_cnt[g] + 1;
`endif
        end
    end

    task automatic wait_ack(input int g, input int budget, output logic got, output logic own,
                            output logic [DW-1:0] rd, output int at);
        got = 1'b0; own = 1'b0; rd = '0; at = -1;
        for (int k = 0; k < budget && !got; k++) begin
            @(posedge clk); #1;
            if (i_ack_w[g] || d_ack_w[g]) begin
                got = 1'b1;
                own = d_ack_w[g];
                rd  = d_ack_w[g] ? d_rdata_w[g] : i_rdata_w[g];
                at  = cyc;
            end
        end
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(posedge clk); #1;
            if (!busy_w[0] && !busy_w[1]) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            n_total++;
            if ({busy_w[g], mem_en_w[g], mem_we_w[g], i_ack_w[g], d_ack_w[g]} !== 5'b0)
                $display("FAIL reset_ctrl[%0d]: got busy/en/we/iack/dack=%b%b%b%b%b want 00000", g,
                         busy_w[g], mem_en_w[g], mem_we_w[g], i_ack_w[g], d_ack_w[g]);
            else n_pass++;
            n_total++;
            if ({mem_addr_w[g], mem_wdata_w[g], i_rdata_w[g], d_rdata_w[g]} !== '0)
                $display("FAIL reset_data[%0d]: got addr=%h wdata=%h irdata=%h drdata=%h want all 0", g,
                         mem_addr_w[g], mem_wdata_w[g], i_rdata_w[g], d_rdata_w[g]);
            else n_pass++;
        end
        rst_f = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (busy_w[0] !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy_w[0]);
        else n_pass++;
    endtask

    task automatic test_single_fetch();
        logic got, own, ok; logic [DW-1:0] rd; int at, t0, d0, e0; logic [W-1:0] exp;
        d0 = d_ack_cnt[0]; e0 = en_cnt[0];
        t0 = cyc;
        i_addr = 16'h0010; i_req = 1'b1;
        exp_q.push_back({OWN_I, 32'h8000_0005, 16'(t0 + 3)});
        @(posedge clk); #1;
        n_total++;
        if ({mem_en_w[0], mem_we_w[0], mem_addr_w[0]} !== {1'b1, 1'b0, 16'h0010})
            $display("FAIL fetch_issue: got en=%b we=%b addr=%h want en=1 we=0 addr=0010",
                     mem_en_w[0], mem_we_w[0], mem_addr_w[0]);
        else n_pass++;
        wait_ack(0, 10, got, own, rd, at);
        i_req = 1'b0;
        exp = exp_q.pop_front();
        n_total++;
        if (!got || {own, rd, 16'(at)} !== exp)
            $display("FAIL fetch_ack: got ack=%b own=%b rdata=%h cyc=%0d want own=%b rdata=%h cyc=%0d",
                     got, own, rd, at, exp[48], exp[47:16], exp[15:0]);
        else n_pass++;
        wait_idle(ok);
        n_total++;
        if (!ok || (d_ack_cnt[0] - d0) != 0 || (en_cnt[0] - e0) != 1)
            $display("FAIL fetch_side: got idle=%b dacks=%0d strobes=%0d want idle=1 dacks=0 strobes=1",
                     ok, d_ack_cnt[0] - d0, en_cnt[0] - e0);
        else n_pass++;
    endtask

    task automatic test_data_write();
        logic got, own, ok; logic [DW-1:0] rd; int at, t0, e0; logic [W-1:0] exp;
        e0 = en_cnt[0];
        t0 = cyc;
        d_addr = 16'h0100; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1; d_req = 1'b1;
        exp_q.push_back({OWN_D, 32'h0000_0000, 16'(t0 + 3)});
        @(posedge clk); #1;
        n_total++;
        if ({mem_en_w[0], mem_we_w[0], mem_addr_w[0], mem_wdata_w[0]} !== {1'b1, 1'b1, 16'h0100, 32'hDEAD_BEEF})
            $display("FAIL write_issue: got en=%b we=%b addr=%h wdata=%h want en=1 we=1 addr=0100 wdata=deadbeef",
                     mem_en_w[0], mem_we_w[0], mem_addr_w[0], mem_wdata_w[0]);
        else n_pass++;
        wait_ack(0, 10, got, own, rd, at);
        d_req = 1'b0; d_we = 1'b0;
        exp = exp_q.pop_front();
        n_total++;
        if (!got || {own, rd, 16'(at)} !== exp)
            $display("FAIL write_ack: got ack=%b own=%b rdata=%h cyc=%0d want own=%b rdata=%h cyc=%0d",
                     got, own, rd, at, exp[48], exp[47:16], exp[15:0]);
        else n_pass++;
        wait_idle(ok);
        n_total++;
        if (!ok || (en_cnt[0] - e0) != 1)
            $display("FAIL write_strobes: got idle=%b strobes=%0d want idle=1 strobes=1", ok, en_cnt[0] - e0);
        else n_pass++;
    endtask

    task automatic test_conflict_starve();
        logic got, own, ok, o; logic [DW-1:0] rd; int at, t0, h0; logic [W-1:0] exp;
        h0 = hit_cnt[0];
        t0 = cyc;
        i_addr = 16'h0010; d_addr = 16'h0200; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            o = ((k % 4) == 3) ? OWN_I : OWN_D;
            exp_q.push_back({o, (o == OWN_I) ? 32'h8000_0005 : 32'h1234_5678, 16'(t0 + 3 + 4 * k)});
        end
        for (int k = 0; k < 8; k++) begin
            wait_ack(0, 12, got, own, rd, at);
            exp = exp_q.pop_front();
            n_total++;
            if (!got || {own, rd, 16'(at)} !== exp)
                $display("FAIL conflict_grant%0d: got ack=%b own=%b rdata=%h cyc=%0d want own=%b rdata=%h cyc=%0d",
                         k, got, own, rd, at, exp[48], exp[47:16], exp[15:0]);
            else n_pass++;
        end
        i_req = 1'b0; d_req = 1'b0;
        wait_idle(ok);
        n_total++;
        if (!ok) $display("FAIL conflict_idle: got busy after 40 cycles want idle");
        else n_pass++;
`ifdef SISC_MEM_ARB_STATS_EN
        n_total++;
        if ((hit_cnt[0] - h0) != 2) $display("FAIL starve_hit: got %0d pulses want 2", hit_cnt[0] - h0);
        else n_pass++;
        n_total++;
        if (conf_cnt_w[0] !== 16'd8) $display("FAIL conf_cnt: got %0d want 8", conf_cnt_w[0]);
        else n_pass++;
`else
        h0 = h0 + 0;
`endif
    endtask

    task automatic test_latency();
        logic got, own, ok; logic [DW-1:0] rd; int at, t0, e1; logic [W-1:0] exp;
        e1 = en_cnt[1];
        t0 = cyc;
        d_addr = 16'h0200; d_we = 1'b0; d_req = 1'b1;
        exp_q.push_back({OWN_D, 32'h1234_5678, 16'(t0 + 6)});
        wait_ack(1, 12, got, own, rd, at);
        d_req = 1'b0;
        exp = exp_q.pop_front();
        n_total++;
        if (!got || {own, rd, 16'(at)} !== exp)
            $display("FAIL lat4_ack: got ack=%b own=%b rdata=%h cyc=%0d want own=%b rdata=%h cyc=%0d",
                     got, own, rd, at, exp[48], exp[47:16], exp[15:0]);
        else n_pass++;
        wait_idle(ok);
        n_total++;
        if (!ok || (en_cnt[1] - e1) != 1)
            $display("FAIL lat4_strobe: got idle=%b strobe cycles=%0d want idle=1 strobe cycles=1", ok, en_cnt[1] - e1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic got, own, ok; logic [DW-1:0] rd; int at, t0; logic [W-1:0] exp;
        logic [AW-1:0] addrs[3];
        logic [DW-1:0] vals[3];
        addrs = '{16'h0044, 16'h0200, 16'h0010};
        vals  = '{32'hCAFE_0044, 32'h1234_5678, 32'h8000_0005};
        t0 = cyc;
        i_addr = addrs[0]; i_req = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back({OWN_I, vals[k], 16'(t0 + 3 + 4 * k)});
        for (int k = 0; k < 3; k++) begin
            wait_ack(0, 12, got, own, rd, at);
            if (k < 2) i_addr = addrs[k+1];
            else i_req = 1'b0;
            exp = exp_q.pop_front();
            n_total++;
            if (!got || {own, rd, 16'(at)} !== exp)
                $display("FAIL b2b_fetch%0d: got ack=%b own=%b rdata=%h cyc=%0d want own=%b rdata=%h cyc=%0d",
                         k, got, own, rd, at, exp[48], exp[47:16], exp[15:0]);
            else n_pass++;
        end
        wait_idle(ok);
        n_total++;
        if (!ok) $display("FAIL b2b_idle: got busy after 40 cycles want idle");
        else n_pass++;
    endtask

    task automatic test_req_drop();
        logic got, own, ok; logic [DW-1:0] rd; int at, t0, e0, a0; logic [W-1:0] exp;
        e0 = en_cnt[0]; a0 = d_ack_cnt[0];
        t0 = cyc;
        d_addr = 16'h0044; d_we = 1'b0; d_req = 1'b1;
        exp_q.push_back({OWN_D, 32'hCAFE_0044, 16'(t0 + 3)});
        @(posedge clk); #1;
        d_req = 1'b0;
        wait_ack(0, 10, got, own, rd, at);
        exp = exp_q.pop_front();
        n_total++;
        if (!got || {own, rd, 16'(at)} !== exp)
            $display("FAIL drop_ack: got ack=%b own=%b rdata=%h cyc=%0d want own=%b rdata=%h cyc=%0d",
                     got, own, rd, at, exp[48], exp[47:16], exp[15:0]);
        else n_pass++;
        wait_idle(ok);
        repeat (4) @(posedge clk);
        #1;
        n_total++;
        if (!ok || (en_cnt[0] - e0) != 1 || (d_ack_cnt[0] - a0) != 1)
            $display("FAIL drop_single: got idle=%b strobes=%0d dacks=%0d want idle=1 strobes=1 dacks=1",
                     ok, en_cnt[0] - e0, d_ack_cnt[0] - a0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic got, own, ok; logic [DW-1:0] rd; int at, t0, a0, a1; logic [W-1:0] exp;
        i_addr = 16'h0010; i_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_total++;
        if (!(busy_w[0] && busy_w[1]))
            $display("FAIL midrst_pre: got busy=%b%b want 11", busy_w[0], busy_w[1]);
        else n_pass++;
        #2;
        rst_f = 1'b0; i_req = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            n_total++;
            if ({busy_w[g], mem_en_w[g], i_ack_w[g], d_ack_w[g], i_rdata_w[g]} !== '0)
                $display("FAIL midrst_async[%0d]: got busy=%b en=%b iack=%b dack=%b irdata=%h want all 0",
                         g, busy_w[g], mem_en_w[g], i_ack_w[g], d_ack_w[g], i_rdata_w[g]);
            else n_pass++;
        end
        a0 = i_ack_cnt[0] + d_ack_cnt[0]; a1 = i_ack_cnt[1] + d_ack_cnt[1];
        repeat (3) @(posedge clk);
        #1;
        rst_f = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_total++;
        if ((i_ack_cnt[0] + d_ack_cnt[0]) != a0 || (i_ack_cnt[1] + d_ack_cnt[1]) != a1)
            $display("FAIL midrst_noack: got acks %0d/%0d after reset want 0/0",
                     i_ack_cnt[0] + d_ack_cnt[0] - a0, i_ack_cnt[1] + d_ack_cnt[1] - a1);
        else n_pass++;
        t0 = cyc;
        i_req = 1'b1;
        exp_q.push_back({OWN_I, 32'h8000_0005, 16'(t0 + 3)});
        wait_ack(0, 10, got, own, rd, at);
        i_req = 1'b0;
        exp = exp_q.pop_front();
        n_total++;
        if (!got || {own, rd, 16'(at)} !== exp)
            $display("FAIL midrst_refetch: got ack=%b own=%b rdata=%h cyc=%0d want own=%b rdata=%h cyc=%0d",
                     got, own, rd, at, exp[48], exp[47:16], exp[15:0]);
        else n_pass++;
        wait_idle(ok);
    endtask

    task automatic test_random();
        logic got, own, ok, use_i; logic [DW-1:0] rd; int at, t0; logic [W-1:0] exp;
        logic [AW-1:0] ra[6];
        logic [DW-1:0] rv[6];
        logic [DW-1:0] d_last;
        d_last = '0;  // data rdata was cleared by the preceding reset and only fetches ran since
        for (int k = 0; k < 6; k++) begin
            ra[k] = 16'h0300 + 16'(k * 16) + 16'($urandom_range(0, 15));
            rv[k] = $urandom;
            t0 = cyc;
            d_addr = ra[k]; d_wdata = rv[k]; d_we = 1'b1; d_req = 1'b1;
            exp_q.push_back({OWN_D, d_last, 16'(t0 + 3)});
            wait_ack(0, 10, got, own, rd, at);
            d_req = 1'b0; d_we = 1'b0;
            exp = exp_q.pop_front();
            n_total++;
            if (!got || {own, rd, 16'(at)} !== exp)
                $display("FAIL rnd_write%0d: got ack=%b own=%b rdata=%h cyc=%0d want own=%b rdata=%h cyc=%0d",
                         k, got, own, rd, at, exp[48], exp[47:16], exp[15:0]);
            else n_pass++;
            wait_idle(ok);
        end
        for (int k = 5; k >= 0; k--) begin
            use_i = 1'($urandom_range(0, 1));
            t0 = cyc;
            if (use_i) begin
                i_addr = ra[k]; i_req = 1'b1;
            end else begin
                d_addr = ra[k]; d_req = 1'b1;
                d_last = rv[k];
            end
            exp_q.push_back({use_i ? OWN_I : OWN_D, rv[k], 16'(t0 + 3)});
            wait_ack(0, 10, got, own, rd, at);
            i_req = 1'b0; d_req = 1'b0;
            exp = exp_q.pop_front();
            n_total++;
            if (!got || {own, rd, 16'(at)} !== exp)
                $display("FAIL rnd_read%0d: got ack=%b own=%b rdata=%h cyc=%0d want own=%b rdata=%h cyc=%0d",
                         k, got, own, rd, at, exp[48], exp[47:16], exp[15:0]);
            else n_pass++;
            wait_idle(ok);
        end
    endtask

    task automatic test_idle_bus();
        for (int g = 0; g < 2; g++) begin
            n_total++;
            if (idle_bus_err[g] != 0)
                $display("FAIL idle_bus[%0d]: got %0d cycles with bus driven outside strobe want 0", g, idle_bus_err[g]);
            else n_pass++;
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        #1 rst_f = 1'b0;
        test_reset();
        test_single_fetch();
        test_data_write();
        test_conflict_starve();
        test_latency();
        test_back_to_back();
        test_req_drop();
        test_reset_mid();
        test_random();
        test_idle_bus();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by 1000000 ns want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sisc_mem_arb.md
Name: sisc_mem_arb

Overview:
Arbitrates the single-ported SISC main memory between the instruction-fetch requester and the data requester (LOD/STR/SWP).
- Sits between the fetch/IR path, the data-memory path and the memory macro.
- Sequences each access as latch → issue → wait → acknowledge.
- Data requester wins conflicts; a starvation guard guarantees fetch progress.

Parameters:
AW, 16, address width
DW, 32, data width
MEM_LAT, 1, memory read latency in cycles after mem_en (1..7)
STARVE_MAX, 3, consecutive data grants with fetch pending before fetch is forced to win (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_f  in  1  reset; one clock; reset is asynchronous and active-low
i_req  in  1  fetch request, level
i_addr  in  AW  fetch address
i_rdata  out  DW  fetch read data, valid with i_ack
i_ack  out  1  fetch completion, one-cycle pulse
d_req  in  1  data request, level
d_we  in  1  1=write, 0=read
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_rdata  out  DW  data read data, valid with d_ack
d_ack  out  1  data completion, one-cycle pulse
mem_en  out  1  memory strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_f low, asynchronous): state=IDLE; all outputs 0; rdata registers 0; starvation counter 0; latched owner/address/data cleared.
- States:
  - IDLE: if any req, pick winner; latch owner, addr, we, wdata → ISSUE. Otherwise stay.
  - ISSUE: mem_en=1; mem_we=latched we; mem_addr/mem_wdata driven from latches → WAIT; wait counter=MEM_LAT.
  - WAIT: decrement counter; at counter==1 capture mem_rdata into the owner's rdata register (skipped for writes) → RESP.
  - RESP: owner's ack=1 for exactly this cycle → IDLE.
- Latency: req sampled in IDLE at cycle N; mem_en in N+1; ack in N+2+MEM_LAT. No pipelining; one outstanding access.
- mem_addr, mem_we, mem_wdata are 0 whenever mem_en=0.
- Arbitration, evaluated only in IDLE:
  - Only one req high: that requester wins.
  - Both high: data wins unless starvation counter==STARVE_MAX, in which case fetch wins.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each data grant made while i_req=1.
  - Clears on any fetch grant.
- Handshake:
  - Requester holds req, addr, we and wdata stable until it sees ack.
  - Inputs are latched in IDLE, so changes after the grant cycle do not affect the access in flight.
  - Req still high in the IDLE cycle after RESP is treated as a new request (back-to-back allowed).
- Req dropped mid-access: the access completes; ack still pulses; the requester ignores it.
- rdata registers hold their value until the next read completes for that requester. d_rdata is unchanged by writes.
- Unknown state encoding → IDLE.
- Reset mid-access: immediate return to IDLE; no ack is produced; mem_en deasserts asynchronously.

Optional Feature:
SISC_MEM_ARB_STATS_EN
- Defined: adds output conf_cnt[15:0]. It is a saturating count of IDLE cycles with both reqs high, reset to 0 by rst_f.
- Adds output starve_hit, a one-cycle pulse whenever the starvation rule forces a fetch grant.
- Undefined: neither port exists and there is no extra logic. Functional behaviour is otherwise identical.

Decomposition:
- Package sisc_mem_pkg holds:
  - state encoding IDLE/ISSUE/WAIT/RESP (2-bit);
  - owner constants OWN_I=0, OWN_D=1;
  - default AW/DW values.
- One sub-module, sisc_arb_pick: combinational winner selection plus the registered starvation counter. Inputs: i_req, d_req, grant strobe. Outputs: winner, starve_hit.

Test Plan:
- Single fetch: MEM_LAT=1; i_req=1, i_addr=0x0010, memory holds 0x8000_0005 → mem_en at cycle 1, i_ack at cycle 3 with i_rdata=0x8000_0005; d_ack never pulses.
- Data write: d_req=1, d_we=1, d_addr=0x0100, d_wdata=0xDEAD_BEEF → single mem_en cycle with mem_we=1 and matching address/data; d_ack at cycle 3; d_rdata stays 0.
- Conflict and starvation: STARVE_MAX=3; i_req and d_req held high → grant order D, D, D, I, D, D, D, I; starve_hit pulses on each forced I (stats build).
- Latency sweep: MEM_LAT=4; data read of 0x0200 holding 0x1234_5678 → d_ack at cycle 6 with d_rdata=0x1234_5678; mem_en high for exactly one cycle.
- Reset mid-access: assert rst_f=0 while in WAIT → busy, mem_en and acks go 0 asynchronously; no ack after release; next i_req completes normally.
- Req drop: d_req pulses for one cycle only → access still completes and d_ack pulses at cycle 3; no second access is issued.
